// File: rtl/regfile_pkg.sv
// Shared register-file geometry and the arbiter lock-state encoding.
package regfile_pkg;
  localparam int RF_DEPTH = 32;
  localparam int RF_AW    = $clog2(RF_DEPTH);
  localparam int RF_DW    = 32;

  typedef enum logic {IDLE, LOCKED} lock_state_e;
endpackage

// File: rtl/regfile_access_arbiter_rr_pick.sv
// Cyclic priority picker: first set mask bit searched from ptr_i+1 upward, wrapping.
// Purely combinational; any_o flags that some bit was found.
module rr_pick #(
  parameter int  N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int j;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    j        = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + 1 + k;
      if (j >= N) j = j - N;
      if (!any_o && mask_i[j[IW-1:0]]) begin
        any_o                = 1'b1;
        onehot_o[j[IW-1:0]]  = 1'b1;
        idx_o                = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter sharing one register file among NUM_REQ agents, with an
// optional time-limited lock for atomic read-modify-write; read data returns 1 cycle after grant.
module regfile_access_arbiter
  import regfile_pkg::*;
#(
  parameter int  NUM_REQ  = 4,
  parameter int  LOCK_MAX = 16,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_lock,
  input  logic [NUM_REQ-1:0]       req_re1,
  input  logic [NUM_REQ-1:0]       req_re2,
  input  logic [NUM_REQ-1:0]       req_we,
  input  logic [NUM_REQ*RF_AW-1:0] req_ra1,
  input  logic [NUM_REQ*RF_AW-1:0] req_ra2,
  input  logic [NUM_REQ*RF_AW-1:0] req_wa,
  input  logic [NUM_REQ*RF_DW-1:0] req_wdata,
  output logic                     rf_read_enable_1,
  output logic                     rf_read_enable_2,
  output logic                     rf_write_enable,
  output logic [RF_AW-1:0]         rf_read_index_1,
  output logic [RF_AW-1:0]         rf_read_index_2,
  output logic [RF_AW-1:0]         rf_write_index,
  output logic [RF_DW-1:0]         rf_write_data,
  input  logic [RF_DW-1:0]         rf_read_data_1,
  input  logic [RF_DW-1:0]         rf_read_data_2,
  output logic                     resp_valid,
  output logic [ID_W-1:0]          resp_id,
  output logic [RF_DW-1:0]         resp_rd1,
  output logic [RF_DW-1:0]         resp_rd2,
  output logic                     locked
);

  localparam int              CNT_W    = $clog2(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);
  localparam logic [ID_W-1:0]  PTR_RST  = ID_W'(NUM_REQ - 1);

  lock_state_e      state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]  resp_id_q, resp_id_d;
  logic             rd1_en_q, rd1_en_d;
  logic             rd2_en_q, rd2_en_d;
  logic             locked_q, locked_d;

  logic [NUM_REQ-1:0] owner_mask;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    win_idx;
  logic               win_vld;
  logic               win_lock;

  // While locked only the owner competes; reset masks everyone so nothing reaches the file.
  assign owner_mask = NUM_REQ'(1) << owner_q;
  assign elig = !rst_n              ? '0 :
                (state_q == LOCKED) ? (req_valid & owner_mask) : req_valid;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .mask_i   (elig),
    .ptr_i    (rr_ptr_q),
    .onehot_o (grant),
    .idx_o    (win_idx),
    .any_o    (win_vld)
  );

  assign req_ready = grant;

  always_comb begin
    win_lock         = 1'b0;
    rf_read_enable_1 = 1'b0;
    rf_read_enable_2 = 1'b0;
    rf_write_enable  = 1'b0;
    rf_read_index_1  = '0;
    rf_read_index_2  = '0;
    rf_write_index   = '0;
    rf_write_data    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_lock         = req_lock[i];
        rf_read_enable_1 = req_re1[i];
        rf_read_enable_2 = req_re2[i];
        rf_write_enable  = req_we[i];
        rf_read_index_1  = req_ra1[i*RF_AW +: RF_AW];
        rf_read_index_2  = req_ra2[i*RF_AW +: RF_AW];
        rf_write_index   = req_wa[i*RF_AW +: RF_AW];
        rf_write_data    = req_wdata[i*RF_DW +: RF_DW];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    rr_ptr_d   = win_vld ? win_idx : rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld && win_lock) begin
          state_d    = LOCKED;
          owner_d    = win_idx;
          lock_cnt_d = '0;
        end
      end
      LOCKED: begin
        lock_cnt_d = lock_cnt_q + 1'b1;
        // Timeout wins over a renewed lock request; the owner's grant this cycle still completes.
        if ((lock_cnt_q == CNT_LAST) || (win_vld && !win_lock)) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    locked_d     = (state_d == LOCKED);
    rd1_en_d     = rf_read_enable_1;
    rd2_en_d     = rf_read_enable_2;
    resp_valid_d = rf_read_enable_1 | rf_read_enable_2;
    resp_id_d    = resp_valid_d ? win_idx : resp_id_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      lock_cnt_q   <= '0;
      rr_ptr_q     <= PTR_RST;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      rd1_en_q     <= 1'b0;
      rd2_en_q     <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lock_cnt_q   <= lock_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      rd1_en_q     <= rd1_en_d;
      rd2_en_q     <= rd2_en_d;
      locked_q     <= locked_d;
    end
  end

  // The file's read data is already registered, so lanes are simply gated by last cycle's enables.
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_rd1   = rd1_en_q ? rf_read_data_1 : '0;
  assign resp_rd2   = rd2_en_q ? rf_read_data_2 : '0;
  assign locked     = locked_q;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Randomized plus directed bench for regfile_access_arbiter with a behavioural register file,
// a reference arbitration model and a response scoreboard drained by an independent monitor.
module tb_regfile_access_arbiter;
  localparam int N    = 4;
  localparam int LM   = 16;
  localparam int ID_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready, req_lock, req_re1, req_re2, req_we;
  logic [N*5-1:0]  req_ra1, req_ra2, req_wa;
  logic [N*32-1:0] req_wdata;
  logic            rf_read_enable_1, rf_read_enable_2, rf_write_enable;
  logic [4:0]      rf_read_index_1, rf_read_index_2, rf_write_index;
  logic [31:0]     rf_write_data;
  bit   [31:0]     rf_read_data_1, rf_read_data_2;
  logic            resp_valid;
  logic [ID_W-1:0] resp_id;
  logic [31:0]     resp_rd1, resp_rd2;
  logic            locked;

  regfile_access_arbiter #(.NUM_REQ(N), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
    .req_re1(req_re1), .req_re2(req_re2), .req_we(req_we),
    .req_ra1(req_ra1), .req_ra2(req_ra2), .req_wa(req_wa), .req_wdata(req_wdata),
    .rf_read_enable_1(rf_read_enable_1), .rf_read_enable_2(rf_read_enable_2),
    .rf_write_enable(rf_write_enable),
    .rf_read_index_1(rf_read_index_1), .rf_read_index_2(rf_read_index_2),
    .rf_write_index(rf_write_index), .rf_write_data(rf_write_data),
    .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
    .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_rd1(resp_rd1), .resp_rd2(resp_rd2), .locked(locked)
  );

  // Per-requester stimulus
  bit        v_s[N], lk_s[N], r1_s[N], r2_s[N], we_s[N];
  bit [4:0]  a1_s[N], a2_s[N], aw_s[N];
  bit [31:0] wd_s[N];

  always_comb begin
    req_valid = '0; req_lock = '0; req_re1 = '0; req_re2 = '0; req_we = '0;
    req_ra1 = '0; req_ra2 = '0; req_wa = '0; req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = v_s[i];
      req_lock[i]  = lk_s[i];
      req_re1[i]   = r1_s[i];
      req_re2[i]   = r2_s[i];
      req_we[i]    = we_s[i];
      req_ra1[i*5 +: 5]    = a1_s[i];
      req_ra2[i*5 +: 5]    = a2_s[i];
      req_wa[i*5 +: 5]     = aw_s[i];
      req_wdata[i*32 +: 32] = wd_s[i];
    end
  end

  // Register file the arbiter drives: registered reads, write-after-read in one edge, x0 fixed.
  bit [31:0] mem [32];
  always @(posedge clk) begin
    if (rf_read_enable_1) rf_read_data_1 <= (rf_read_index_1 == 5'd0) ? 32'd0 : mem[rf_read_index_1];
    if (rf_read_enable_2) rf_read_data_2 <= (rf_read_index_2 == 5'd0) ? 32'd0 : mem[rf_read_index_2];
    if (rf_write_enable && rf_write_index != 5'd0) mem[rf_write_index] <= rf_write_data;
  end

  // Reference model state
  bit [31:0] ref_rf [32];
  int m_ptr = N - 1;
  bit m_locked = 1'b0;
  int m_owner = 0;
  int m_cnt = 0;
  int last_w = -1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int        due;
    int        id;
    bit [31:0] d1;
    bit [31:0] d2;
  } exp_t;
  exp_t sbq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic eval();
    int w;
    logic [N-1:0]  exp_ready;
    logic [49:0]   exp_drv;
    exp_t e;
    if (!rst_n) begin
      check("ready_in_reset", req_ready, 0);
      check("rf_en_in_reset", {rf_read_enable_1, rf_read_enable_2, rf_write_enable}, 0);
      m_ptr = N - 1; m_locked = 0; m_cnt = 0; last_w = -1;
      return;
    end
    w = -1;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (w < 0 && v_s[j] && (!m_locked || j == m_owner)) w = j;
    end
    exp_ready = '0;
    exp_drv   = '0;
    if (w >= 0) begin
      exp_ready[w] = 1'b1;
      exp_drv = {r1_s[w], r2_s[w], we_s[w], a1_s[w], a2_s[w], aw_s[w], wd_s[w]};
    end
    check("grant", req_ready, exp_ready);
    check("locked", locked, m_locked);
    check("rf_drive", {rf_read_enable_1, rf_read_enable_2, rf_write_enable, rf_read_index_1,
                       rf_read_index_2, rf_write_index, rf_write_data}, exp_drv);
    if (w >= 0) begin
      if (r1_s[w] || r2_s[w]) begin
        e.due = cyc + 1;
        e.id  = w;
        e.d1  = r1_s[w] ? ref_rf[a1_s[w]] : 32'd0;
        e.d2  = r2_s[w] ? ref_rf[a2_s[w]] : 32'd0;
        sbq.push_back(e);
      end
      if (we_s[w] && aw_s[w] != 5'd0) ref_rf[aw_s[w]] = wd_s[w];
      m_ptr = w;
    end
    if (m_locked) begin
      if (m_cnt == LM - 1 || (w >= 0 && !lk_s[w])) begin
        m_locked = 0; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else if (w >= 0 && lk_s[w]) begin
      m_locked = 1; m_owner = w; m_cnt = 0;
    end
    last_w = w;
  endtask

  // Response monitor
  always @(negedge clk) begin
    exp_t e;
    if (cyc >= 1) begin
      if (!rst_n) begin
        check("resp_valid_in_reset", resp_valid, 0);
      end else if (resp_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_resp: got id %0d with no pending read (cycle %0d)", resp_id, cyc);
        end else begin
          e = sbq.pop_front();
          check("resp_due", cyc, e.due);
          check("resp_id", resp_id, e.id);
          check("resp_rd1", resp_rd1, e.d1);
          check("resp_rd2", resp_rd2, e.d2);
        end
      end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
        checks++; failures++;
        $display("FAIL missing_resp: got none expected id %0d (cycle %0d)", sbq[0].id, cyc);
        void'(sbq.pop_front());
      end
    end
  end

  task automatic cycle();
    @(negedge clk);
    eval();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < N; i++) begin
      v_s[i] = 0; lk_s[i] = 0; r1_s[i] = 0; r2_s[i] = 0; we_s[i] = 0;
      a1_s[i] = 0; a2_s[i] = 0; aw_s[i] = 0; wd_s[i] = 0;
    end
  endtask

  task automatic all_read(input bit [4:0] ra);
    for (int i = 0; i < N; i++) begin
      v_s[i] = 1; r1_s[i] = 1; a1_s[i] = ra;
    end
  endtask

  task automatic do_reset();
    idle();
    cycle(); cycle();
    rst_n = 0;
    sbq.delete();
    cycle(); cycle();
    rst_n = 1;
  endtask

  task automatic rand_req(input int i);
    v_s[i]  = ($urandom_range(0, 3) != 0);
    lk_s[i] = ($urandom_range(0, 9) == 0);
    r1_s[i] = 1'($urandom_range(0, 1));
    r2_s[i] = 1'($urandom_range(0, 1));
    we_s[i] = 1'($urandom_range(0, 1));
    a1_s[i] = 5'($urandom_range(0, 7));
    a2_s[i] = 5'($urandom_range(0, 31));
    aw_s[i] = 5'($urandom_range(0, 7));
    wd_s[i] = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    idle();
    rst_n = 0;
    repeat (3) cycle();
    rst_n = 1;

    // Plain round-robin over four readers
    all_read(5'd3);
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("rr_order", last_w, k % N);
    end

    // Lock held by req0 for three transactions, released by the fourth
    do_reset();
    all_read(5'd1);
    lk_s[0] = 1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("lock_owner_grant", last_w, 0);
    end
    lk_s[0] = 0;
    cycle();
    check("lock_release_grant", last_w, 0);
    cycle();
    check("after_lock_grant", last_w, 1);

    // Continuous lock by req2 hits the timeout
    do_reset();
    v_s[2] = 1; r1_s[2] = 1; a1_s[2] = 5'd2; lk_s[2] = 1;
    cycle();
    check("timeout_first", last_w, 2);
    all_read(5'd2);
    for (int k = 0; k < LM; k++) begin
      cycle();
      check("timeout_hold", last_w, 2);
    end
    cycle();
    check("timeout_next", last_w, 3);
    lk_s[2] = 0;

    // Write then read-next-cycle by a different requester
    idle(); cycle();
    v_s[1] = 1; we_s[1] = 1; aw_s[1] = 5'd5; wd_s[1] = 32'hDEADBEEF;
    cycle();
    idle();
    v_s[2] = 1; r1_s[2] = 1; a1_s[2] = 5'd5;
    cycle();

    // Same-transaction read and write of x7 returns the old value
    idle();
    v_s[0] = 1; we_s[0] = 1; aw_s[0] = 5'd7; wd_s[0] = 32'h22;
    cycle();
    r1_s[0] = 1; a1_s[0] = 5'd7; wd_s[0] = 32'h11;
    cycle();
    idle();
    v_s[0] = 1; r1_s[0] = 1; a1_s[0] = 5'd7;
    cycle();

    // x0 ignores writes
    idle();
    v_s[3] = 1; we_s[3] = 1; aw_s[3] = 5'd0; wd_s[3] = 32'hFFFFFFFF;
    cycle();
    idle();
    v_s[3] = 1; r1_s[3] = 1; r2_s[3] = 1;
    cycle();
    idle(); cycle(); cycle();

    // Reset while a read is in flight and a lock is held
    v_s[0] = 1; lk_s[0] = 1; r1_s[0] = 1; a1_s[0] = 5'd5;
    cycle();
    a1_s[0] = 5'd6;
    @(negedge clk);
    eval();
    #1;
    rst_n = 0;
    sbq.delete();
    idle();
    @(posedge clk);
    #1;
    cycle();
    rst_n = 1;
    cycle();
    cycle();

    // Random traffic; a pending unserved request keeps its payload
    for (int i = 0; i < N; i++) rand_req(i);
    for (int n = 0; n < 2000; n++) begin
      cycle();
      for (int i = 0; i < N; i++)
        if (!(v_s[i] && last_w != i)) rand_req(i);
    end

    idle();
    repeat (3) cycle();
    check("scoreboard_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_access_arbiter.md
# regfile_access_arbiter

Round-robin arbiter that shares the 32×32 register file (two registered read ports, one write port, x0 hard-wired to zero) among `NUM_REQ` requesters. Each cycle it grants at most one requester, drives that requester's read/write request onto the register-file ports, and returns read data one cycle later, tagged with the requester ID. An optional lock lets one requester hold the file for an atomic read-modify-write sequence, with a forced timeout. Sits between the pipeline/DMA/debug agents and the register file.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8)
- `LOCK_MAX`, 16: maximum cycles a lock may be held before forced release (≥2)
- `ID_W`, `$clog2(NUM_REQ)`: derived, not overridable
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  NUM_REQ  per-requester request valid
- `req_ready`  out  NUM_REQ  one-hot grant; the transfer happens when valid&ready
- `req_lock`  in  NUM_REQ  request or keep the lock with this transaction
- `req_re1`, `req_re2`, `req_we`  in  NUM_REQ each  per-requester port enables
- `req_ra1`, `req_ra2`, `req_wa`  in  NUM_REQ*5  packed indices, requester i at [5i+4:5i]
- `req_wdata`  in  NUM_REQ*32  packed write data
- `rf_read_enable_1`, `rf_read_enable_2`, `rf_write_enable`  out  1  to register file
- `rf_read_index_1`, `rf_read_index_2`, `rf_write_index`  out  5  to register file
- `rf_write_data`  out  32  to register file
- `rf_read_data_1`, `rf_read_data_2`  in  32  from register file (registered, 1-cycle latency)
- `resp_valid`  out  1  read response valid
- `resp_id`  out  ID_W  requester that owns the response
- `resp_rd1`, `resp_rd2`  out  32  read data; port-disabled lanes return 0, never Z
- `locked`  out  1  lock currently held

## Operation
- Grant:
  - Eligible requesters are those with `req_valid` set; in LOCKED state only the owner is eligible.
  - The winner is the first eligible index searched cyclically starting at `rr_ptr+1`.
  - `req_ready` is a combinational one-hot of the winner, or all zero.
- RF drive:
  - The winner's enables, indices and data pass straight to the `rf_*` outputs.
  - With no grant, all three enables are 0 and indices/data are 0.
- `rr_ptr`:
  - Updated to the winner index on every grant; unchanged otherwise.
  - Resets to `NUM_REQ-1`, so requester 0 wins first.
- Lock FSM, states IDLE and LOCKED:
  - IDLE→LOCKED: granted transaction has `req_lock`=1. Owner = winner, `lock_cnt`=0.
  - LOCKED→IDLE: owner's granted transaction has `req_lock`=0, or `lock_cnt` reaches `LOCK_MAX-1`.
  - `lock_cnt` increments every cycle in LOCKED, whether or not the owner is granted.
  - On timeout the current cycle's owner grant still completes. The following cycle is IDLE with normal round-robin, starting after the owner.
- Response:
  - A grant with re1|re2 in cycle N gives `resp_valid`=1 in cycle N+1, with `resp_id` = winner.
  - `resp_rd1`/`resp_rd2` = `rf_read_data_x` if the respective enable was set in cycle N, else 0.
  - A write-only grant produces no response.
- Hazards:
  - A read and write in the same granted transaction to the same index returns the OLD value.
  - A write granted in cycle N is visible to a read granted in cycle N+1.
  - Writes to index 0 are granted and acknowledged but have no effect; reads of x0 return 0.

## Timing
- Grant and `req_ready` are combinational from `req_valid`, lock state and `rr_ptr`; there are no combinational paths from `rf_read_data_*`.
- Read latency: 1 cycle grant→`resp_valid`. Throughput: 1 transaction/cycle.
- Reset values (synchronous, `rst_n`=0 at a rising edge):
  - `resp_valid`=0, `resp_id`=0, `resp_rd1`/`resp_rd2`=0.
  - `locked`=0, state IDLE, `lock_cnt`=0, `rr_ptr`=`NUM_REQ-1`.
- While `rst_n`=0, `req_ready`=0 and all `rf_*` enables are 0.
- Reset mid-operation: a response in flight from the grant before reset is dropped (`resp_valid`=0 the cycle after reset), and any held lock is released.
- Requesters must hold payload stable while valid&!ready. Dropping valid before grant is legal.

## Structure
- Shared package `regfile_pkg`: `RF_DEPTH`=32, `RF_AW`=5, `RF_DW`=32, and the lock-state enum {IDLE, LOCKED}.
- One sub-module, `rr_pick`: a parameterized cyclic priority picker taking a mask and pointer, returning a one-hot result and an index.
- Lock FSM, response register and muxing stay in the top.

## Test plan
- Reset then `req_valid`=4'b1111, all read re1 ra1=3 → grants in order 0,1,2,3,0. `resp_valid` each cycle from cycle 1, with `resp_id` trailing the grant by 1.
- Req1 writes x5=0xDEADBEEF in cycle N; req2 reads ra1=5 in N+1 → `resp_rd1`=0xDEADBEEF in N+2, `resp_id`=2.
- Single transaction re1 ra1=7, we wa=7 wdata=0x11 with x7 previously 0x22 → response 0x22; a later read returns 0x11.
- Req0 lock=1 for 3 transactions, then lock=0, while req1..3 are valid → only req0 granted for 4 cycles, `locked`=1 for cycles 1–3, then req1 granted.
- Req2 holds lock=1 continuously with `LOCK_MAX`=16 → forced release after 16 locked cycles, next grant goes to req3.
- Read grant in cycle N, `rst_n`=0 at edge N+1 → `resp_valid`=0. Write of x0=0xFFFFFFFF then read x0 → `resp_rd1`=0.
